// File: rtl/nv_pipe_skid2.sv
// ---------------------------------------------------------------------------
// nv_pipe_skid2
//   Two-entry FIFO skid buffer for one branch of a handshake fork. Entries
//   leave in the order they arrived. The head entry is held in its own
//   register, so pd changes only on a pop or on a push into an empty buffer.
//
// Ports:
//   clk    in   clock
//   rstn   in   asynchronous active-low reset, clears all entries
//   push   in   write pd_in at the tail (never asserted while full)
//   pd_in  in   payload to write, DW bits
//   pop    in   remove the head entry (never asserted while empty)
//   cnt    out  number of entries held, 0..2
//   pd     out  head entry payload, DW bits
//   full   out  cnt == 2
//   vld    out  cnt != 0
// ---------------------------------------------------------------------------
module nv_pipe_skid2 #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] pd_in,
    input  logic          pop,
    output logic [1:0]    cnt,
    output logic [DW-1:0] pd,
    output logic          full,
    output logic          vld
);

    // Second entry. It is only meaningful when cnt == 2.
    logic [DW-1:0] tail;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= 2'd0;
            pd   <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        pd <= pd_in;
                    end else begin
                        tail <= pd_in;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    // The head advances. When cnt was 1, tail is stale, but
                    // vld drops, so pd is a don't-care.
                    pd  <= tail;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    // One entry leaves and one arrives, so cnt is unchanged.
                    // With a single entry, the new data becomes the head.
                    // With two entries, the old tail moves to the head.
                    if (cnt == 2'd1) begin
                        pd <= pd_in;
                    end else begin
                        pd   <= tail;
                        tail <= pd_in;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign full = (cnt == 2'd2);
    assign vld  = (cnt != 2'd0);

    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (!rstn) !(push && full));
    a_no_pop_when_empty : assert property (
        @(posedge clk) disable iff (!rstn) !(pop && !vld));

endmodule

// File: rtl/nv_pipe_fork2.sv
// ---------------------------------------------------------------------------
// nv_pipe_fork2
//   Handshake fork. One valid/ready producer stream is copied into two
//   independent consumer branches, A and B. Each accepted input is pushed
//   into both branch skid buffers in the same cycle. A stalled branch
//   therefore blocks the producer only after its own two entries fill.
//
// Ports:
//   nvdla_core_clk   in   core clock
//   nvdla_core_rstn  in   asynchronous active-low reset
//   in_pvld          in   producer valid
//   in_prdy          out  producer ready
//   in_pd            in   producer payload, DW bits
//   a_pvld/b_pvld    out  branch valid
//   a_prdy/b_prdy    in   branch ready
//   a_pd/b_pd        out  branch payload, DW bits
// ---------------------------------------------------------------------------
module nv_pipe_fork2 #(
    parameter int DW = 32
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          in_pvld,
    output logic          in_prdy,
    input  logic [DW-1:0] in_pd,
    output logic          a_pvld,
    input  logic          a_prdy,
    output logic [DW-1:0] a_pd,
    output logic          b_pvld,
    input  logic          b_prdy,
    output logic [DW-1:0] b_pd
);

    logic       push;
    logic       a_pop;
    logic       b_pop;
    logic [1:0] a_cnt;
    logic [1:0] b_cnt;
    logic       a_full;
    logic       b_full;

    // in_prdy depends only on the registered counts. Keeping a_prdy/b_prdy
    // out of this path costs a one-cycle bubble when a full branch drains.
    assign in_prdy = (a_cnt != 2'd2) && (b_cnt != 2'd2);
    assign push    = in_pvld && in_prdy;
    assign a_pop   = a_pvld && a_prdy;
    assign b_pop   = b_pvld && b_prdy;

    nv_pipe_skid2 #(.DW(DW)) u_skid_a (
        .clk   (nvdla_core_clk),
        .rstn  (nvdla_core_rstn),
        .push  (push),
        .pd_in (in_pd),
        .pop   (a_pop),
        .cnt   (a_cnt),
        .pd    (a_pd),
        .full  (a_full),
        .vld   (a_pvld)
    );

    nv_pipe_skid2 #(.DW(DW)) u_skid_b (
        .clk   (nvdla_core_clk),
        .rstn  (nvdla_core_rstn),
        .push  (push),
        .pd_in (in_pd),
        .pop   (b_pop),
        .cnt   (b_cnt),
        .pd    (b_pd),
        .full  (b_full),
        .vld   (b_pvld)
    );

    a_ready_matches_full : assert property (
        @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        in_prdy == !(a_full || b_full));

endmodule

// File: tb/tb_nv_pipe_fork2.sv
// Self-checking bench for nv_pipe_fork2. The main instance uses DW=8. A second
// DW=1 instance covers the minimum width. The reference model keeps one queue
// of undelivered items per branch.
module tb_nv_pipe_fork2;

    logic       clk;
    logic       rstn;

    // Main instance, DW = 8.
    logic       in_pvld;
    logic       in_prdy;
    logic [7:0] in_pd;
    logic       a_pvld;
    logic       a_prdy;
    logic [7:0] a_pd;
    logic       b_pvld;
    logic       b_prdy;
    logic [7:0] b_pd;

    // Narrow instance, DW = 1.
    logic       n_in_pvld;
    logic       n_in_prdy;
    logic [0:0] n_in_pd;
    logic       n_a_pvld;
    logic       n_a_prdy;
    logic [0:0] n_a_pd;
    logic       n_b_pvld;
    logic       n_b_prdy;
    logic [0:0] n_b_pd;

    int vectors;
    int miscompares;

    // Items accepted but not yet delivered on each branch, oldest first.
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    nv_pipe_fork2 #(.DW(8)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .in_pvld         (in_pvld),
        .in_prdy         (in_prdy),
        .in_pd           (in_pd),
        .a_pvld          (a_pvld),
        .a_prdy          (a_prdy),
        .a_pd            (a_pd),
        .b_pvld          (b_pvld),
        .b_prdy          (b_prdy),
        .b_pd            (b_pd)
    );

    nv_pipe_fork2 #(.DW(1)) dut_narrow (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .in_pvld         (n_in_pvld),
        .in_prdy         (n_in_prdy),
        .in_pd           (n_in_pd),
        .a_pvld          (n_a_pvld),
        .a_prdy          (n_a_prdy),
        .a_pd            (n_a_pd),
        .b_pvld          (n_b_pvld),
        .b_prdy          (n_b_prdy),
        .b_pd            (n_b_pd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compares the main instance outputs with the queue model. The payload is
    // checked only while its valid is expected high.
    task automatic checkModel();
        int exp_rdy;
        exp_rdy = (qa.size() != 2 && qb.size() != 2) ? 1 : 0;
        checkOutput("in_prdy", {31'd0, in_prdy}, exp_rdy);
        checkOutput("a_pvld", {31'd0, a_pvld}, (qa.size() != 0) ? 1 : 0);
        checkOutput("b_pvld", {31'd0, b_pvld}, (qb.size() != 0) ? 1 : 0);
        if (qa.size() != 0) checkOutput("a_pd", {24'd0, a_pd}, {24'd0, qa[0]});
        if (qb.size() != 0) checkOutput("b_pd", {24'd0, b_pd}, {24'd0, qb[0]});
    endtask

    // Runs one cycle. It checks the outputs at the falling edge, then drives
    // the inputs. At the rising edge it applies the handshakes to the model.
    task automatic applyStimulus(input logic pvld, input logic [7:0] pd,
                                 input logic ardy, input logic brdy,
                                 output logic accepted);
        logic acc, pa, pb;
        @(negedge clk);
        checkModel();
        in_pvld = pvld;
        in_pd   = pd;
        a_prdy  = ardy;
        b_prdy  = brdy;
        acc = pvld && (qa.size() != 2) && (qb.size() != 2);
        pa  = ardy && (qa.size() != 0);
        pb  = brdy && (qb.size() != 0);
        @(posedge clk);
        if (pa) void'(qa.pop_front());
        if (pb) void'(qb.pop_front());
        if (acc) begin
            qa.push_back(pd);
            qb.push_back(pd);
        end
        accepted = acc;
    endtask

    // Offers one value until the model accepts it. Gives up after a bounded
    // number of cycles and records the expiry as a failed comparison.
    task automatic sendItem(input logic [7:0] pd, input logic ardy, input logic brdy);
        logic acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            applyStimulus(1'b1, pd, ardy, brdy, acc);
            tries++;
        end
        checkOutput("send_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        qa.delete();
        qb.delete();
        checkOutput("rst_in_prdy", {31'd0, in_prdy}, 32'd1);
        checkOutput("rst_a_pvld", {31'd0, a_pvld}, 32'd0);
        checkOutput("rst_b_pvld", {31'd0, b_pvld}, 32'd0);
        checkOutput("rst_a_pd", {24'd0, a_pd}, 32'd0);
        checkOutput("rst_b_pd", {24'd0, b_pd}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic acc;
        vectors     = 0;
        miscompares = 0;
        rstn      = 1'b0;
        in_pvld   = 1'b0;
        in_pd     = 8'h00;
        a_prdy    = 1'b0;
        b_prdy    = 1'b0;
        n_in_pvld = 1'b0;
        n_in_pd   = 1'b0;
        n_a_prdy  = 1'b0;
        n_b_prdy  = 1'b0;
        repeat (2) @(posedge clk);
        resetDut();

        // Back-to-back stream with both branches ready.
        sendItem(8'h11, 1'b1, 1'b1);
        sendItem(8'h22, 1'b1, 1'b1);
        sendItem(8'h33, 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, acc);

        // B stalls while A runs. B fills, then it is released.
        sendItem(8'h01, 1'b1, 1'b0);
        sendItem(8'h02, 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b1, 8'h03, 1'b1, 1'b0, acc);
        sendItem(8'h03, 1'b1, 1'b1);
        sendItem(8'h04, 1'b1, 1'b1);
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, acc);

        // Both branches full, then both ready in one cycle: expect a bubble.
        sendItem(8'hA1, 1'b0, 1'b0);
        sendItem(8'hA2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA3, 1'b1, 1'b1, acc);
        checkOutput("bubble_no_accept", {31'd0, acc}, 32'd0);
        applyStimulus(1'b1, 8'hA3, 1'b1, 1'b1, acc);
        checkOutput("accept_after_bubble", {31'd0, acc}, 32'd1);
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, acc);

        // Reset with A holding two entries and B holding one.
        sendItem(8'hC1, 1'b0, 1'b0);
        sendItem(8'hC2, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, acc);
        checkOutput("pre_rst_qa", qa.size(), 32'd2);
        checkOutput("pre_rst_qb", qb.size(), 32'd1);
        resetDut();
        sendItem(8'h5A, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, acc);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
                          ($urandom % 3) != 0, acc);
        end
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, acc);

        // DW=1 build: a single transfer of 1.
        @(negedge clk);
        checkOutput("n_idle_prdy", {31'd0, n_in_prdy}, 32'd1);
        checkOutput("n_idle_a_pvld", {31'd0, n_a_pvld}, 32'd0);
        n_in_pvld = 1'b1;
        n_in_pd   = 1'b1;
        n_a_prdy  = 1'b1;
        n_b_prdy  = 1'b1;
        @(negedge clk);
        n_in_pvld = 1'b0;
        n_in_pd   = 1'b0;
        checkOutput("n_a_pvld", {31'd0, n_a_pvld}, 32'd1);
        checkOutput("n_a_pd", {31'd0, n_a_pd}, 32'd1);
        checkOutput("n_b_pvld", {31'd0, n_b_pvld}, 32'd1);
        checkOutput("n_b_pd", {31'd0, n_b_pd}, 32'd1);
        @(negedge clk);
        checkOutput("n_a_drained", {31'd0, n_a_pvld}, 32'd0);
        checkOutput("n_b_drained", {31'd0, n_b_pvld}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
